input_skew_feeder: RTL

//  Upstream stage of the PE systolic array. Buffers input vectors (one element per array row)
//  and drives the array's west edge with diagonal skew: row r lags row 0 by r advance steps.

---
 rtl/tpu_pkg.sv | 19 +
 rtl/feeder_fifo.sv | 60 ++++++
 rtl/input_skew_feeder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array front end: fixed-point element type and feeder FSM states.
package tpu_pkg;

  typedef logic signed [15:0] fxp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  localparam int STALL_CNT_W = 32;

  // Advances of zero fill needed after the last vector so the far corner flushes out.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Show-ahead vector FIFO for the skew feeder; full/empty are registered from the next pointers.
module feeder_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  always_comb begin
    wr_ptr_next = push_ok ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    empty_next  = (wr_ptr_next == rd_ptr_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/input_skew_feeder.sv
// West-edge feeder for the PE array: buffers vectors, skews row r by r advances, then drains.
// Optional FEEDER_STALL_STATS_EN adds a saturating stall_cnt output.
module input_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic                       sa_start,
  output logic                       busy,
  output logic                       done
`ifdef FEEDER_STALL_STATS_EN
  ,output logic [STALL_CNT_W-1:0]    stall_cnt
`endif
);

  localparam int VEC_W = ROWS * DATA_WIDTH;
  localparam int EW    = DATA_WIDTH + 1;
  localparam int CNT_W = $clog2(ROWS + COLS);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drain_len(ROWS, COLS));
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  feeder_state_e    state_reg, state_next;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic [VEC_W:0]   fifo_rd_data;
  logic             fifo_full, fifo_empty, push, pop_last;
  logic             pop, advance, done_next;
  logic             sa_start_reg, done_reg;

  assign push     = in_valid && !fifo_full;
  assign pop_last = fifo_rd_data[VEC_W];

  feeder_fifo #(
    .WIDTH(VEC_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_data({in_last, in_data}),
    .pop    (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = STREAM;
      STREAM:  if (!fifo_empty && pop_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter==0 drain cycle only closes the matrix; zero-fill advances happen while it is non-zero.
  always_comb begin
    pop       = 1'b0;
    advance   = 1'b0;
    done_next = 1'b0;
    case (state_reg)
      STREAM: begin
        pop     = !fifo_empty;
        advance = !fifo_empty;
      end
      DRAIN: begin
        advance   = (drain_cnt_reg != '0);
        done_next = (drain_cnt_reg == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_reg <= '0;
    end else if (state_reg == STREAM && state_next == DRAIN) begin
      drain_cnt_reg <= DRAIN_LOAD;
    end else if (state_reg == DRAIN && drain_cnt_reg != '0) begin
      drain_cnt_reg <= drain_cnt_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_start_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      sa_start_reg <= advance;
      done_reg     <= done_next;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [DATA_WIDTH-1:0] elem;
    logic [DATA_WIDTH-1:0] row_q;

    assign elem = pop ? fifo_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (gi == 0) begin : g_direct
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          row_q <= '0;
        else if (advance) row_q <= elem;
      end
    end else begin : g_shift
      // gi entries of {valid, data}; the oldest entry sits at the top of the vector.
      logic [EW-1:0]    entry;
      logic [gi*EW-1:0] sr_reg, sr_next;

      assign entry = {pop, elem};
      if (gi == 1) begin : g_one
        assign sr_next = entry;
      end else begin : g_many
        assign sr_next = {sr_reg[(gi-1)*EW-1:0], entry};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr_reg <= '0;
          row_q  <= '0;
        end else if (advance) begin
          sr_reg <= sr_next;
          row_q  <= sr_reg[gi*EW-1] ? sr_reg[gi*EW-2 -: DATA_WIDTH] : '0;
        end
      end
    end

    assign row_data[gi*DATA_WIDTH +: DATA_WIDTH] = row_q;
  end

`ifdef FEEDER_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == STREAM && fifo_empty && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

  assign in_ready = !fifo_full;
  assign sa_start = sa_start_reg;
  assign done     = done_reg;
  assign busy     = (state_reg != IDLE);

endmodule
